// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide: one bit per clock on operand magnitudes,
// sign fix-up at the end, 64-bit result split into hi/lo words.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    // state | meaning
    // IDLE  | waiting for start
    // PREP  | form magnitudes, record result signs, detect divide by zero
    // ITER  | one multiplier / quotient bit per cycle, DATA_WIDTH cycles
    // FIX   | negate where needed, load hi/lo
    // DONE  | one-cycle done pulse; start here chains the next operation
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t          state_q;
    logic            op_q;
    logic [W-1:0]    a_q, b_q;
    logic [W:0]      mag_q;
    logic [2*W-1:0]  acc_q;
    logic [W:0]      rem_q;
    logic [CW-1:0]   cnt_q;
    logic            sign_lo_q, sign_hi_q, dbz_pend_q;
    logic            busy_q, done_q, dbz_q;
    logic [W-1:0]    hi_q, lo_q;

    logic [W:0]      mag_a, mag_b;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_acc_d;
    logic [W+1:0]    div_shift, div_diff;
    logic [W:0]      div_rem_d;
    logic [2*W-1:0]  div_acc_d;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix;

    // Sign-extend by one bit so the most-negative value still has a representable magnitude.
    function automatic logic [W:0] abs_ext(input logic [W-1:0] v);
        logic [W:0] s;
        s = {v[W-1], v};
        return v[W-1] ? (~s + (W+1)'(1)) : s;
    endfunction

    always_comb begin
        mag_a     = abs_ext(a_q);
        mag_b     = abs_ext(b_q);
        mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*W-1:W]} + mag_q) : {1'b0, acc_q[2*W-1:W]};
        mul_acc_d = {mul_sum, acc_q[W-1:1]};
        div_shift = {rem_q, acc_q[W-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        div_rem_d = div_diff[W+1] ? div_shift[W:0] : div_diff[W:0];
        div_acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_diff[W+1]};
        prod_fix  = sign_lo_q ? (~acc_q + (2*W)'(1)) : acc_q;
        quo_fix   = sign_lo_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
        rem_fix   = sign_hi_q ? (~rem_q[W-1:0] + W'(1)) : rem_q[W-1:0];
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            mag_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            sign_lo_q  <= 1'b0;
            sign_hi_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PREP: begin
                    sign_lo_q  <= a_q[W-1] ^ b_q[W-1];
                    sign_hi_q  <= op_q & a_q[W-1];
                    dbz_pend_q <= op_q & (b_q == '0);
                    mag_q      <= op_q ? mag_b : mag_a;
                    acc_q      <= {{W{1'b0}}, (op_q ? mag_a[W-1:0] : mag_b[W-1:0])};
                    rem_q      <= '0;
                    cnt_q      <= '0;
                    state_q    <= S_ITER;
                end
                S_ITER: begin
                    if (op_q) begin
                        acc_q <= div_acc_d;
                        rem_q <= div_rem_d;
                    end else begin
                        acc_q <= mul_acc_d;
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W-1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (op_q) begin
                        if (dbz_pend_q) begin
                            hi_q  <= a_q;
                            lo_q  <= '1;
                            dbz_q <= 1'b1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed products, quotients, latency,
// ignored starts, mid-operation reset and back-to-back operation.
module tb_mul_div_unit;
    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive start for one edge; returns #1 after the accept edge (cycle 1).
    task automatic start_op(input logic o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Waits for done; cyc is the cycle number (accept edge = 0) in which done is seen.
    task automatic wait_done(output int cyc, input bit glitch);
        bit got;
        got = 1'b0;
        cyc = 1;
        while (cyc <= 60 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (glitch) begin
                    if (cyc == 5 || cyc == 20) begin
                        start = 1'b1; op = 1'b1; a = 32'd999; b = 32'd3;
                    end else begin
                        start = 1'b0;
                    end
                end
                @(posedge clock);
                #1 cyc++;
            end
        end
        if (!got) chk("done_timeout", 64'(cyc), 64'd35);
    endtask

    task automatic run(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        start_op(o, x, y);
        wait_done(cyc, 1'b0);
        chk({tag, "_lat"}, 64'(cyc), 64'd35);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int  cyc;
        bit  seen;
        clear = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #22;
        chk("rst_outs", {27'd0, busy, done, div_by_zero, 2'b0, hi}, 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clock) clear = 1'b1;

        // 7 * -3 with detailed timing
        start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("busy_c1", 64'(busy), 64'd1);
        wait_done(cyc, 1'b0);
        chk("m1_lat", 64'(cyc), 64'd35);
        chk("m1_busy_at_done", 64'(busy), 64'd0);
        chk("m1_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("m1_lo", 64'(lo), 64'hFFFF_FFEB);
        @(posedge clock); #1;
        chk("m1_done_pulse", 64'(done), 64'd0);
        chk("m1_hold", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        run("m_minmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run("d_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("d_7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run("d_min_neg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run("m_big", 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001);

        // divide by zero, then a normal divide clears the flag at accept
        run("dz", 1'b1, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        chk("dz_flag", 64'(div_by_zero), 64'd1);
        @(posedge clock); #1;
        chk("dz_flag_held", 64'(div_by_zero), 64'd1);
        start_op(1'b1, 32'd100, 32'd7);
        chk("dz_cleared", 64'(div_by_zero), 64'd0);
        wait_done(cyc, 1'b0);
        chk("d100_7_lat", 64'(cyc), 64'd35);
        chk("d100_7", {hi, lo}, {32'd2, 32'd14});
        chk("d100_7_flag", 64'(div_by_zero), 64'd0);

        // start pulses mid-operation are ignored
        start_op(1'b0, 32'd6, 32'd7);
        wait_done(cyc, 1'b1);
        start = 1'b0;
        chk("ign_lat", 64'(cyc), 64'd35);
        chk("ign_res", {hi, lo}, {32'd0, 32'd42});

        // reset during ITER
        start_op(1'b0, 32'd123, 32'd456);
        repeat (9) begin @(posedge clock); #1; end
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 clear = 1'b0;
        #1;
        chk("mid_rst_outs", {29'd0, busy, done, div_by_zero, hi}, 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        @(negedge clock) clear = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) seen = 1'b1;
        end
        chk("no_done_after_rst", 64'(seen), 64'd0);
        run("m3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);

        // back-to-back with start held through DONE
        @(negedge clock);
        op = 1'b0; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clock); #1;
        wait_done(cyc, 1'b0);
        chk("b2b_first", {hi, lo}, {32'd0, 32'd25});
        a = 32'd9; b = 32'hFFFF_FFFE;
        @(posedge clock); #1 start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(cyc, 1'b0);
        chk("b2b_gap", 64'(cyc), 64'd35);
        chk("b2b_second", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle signed multiply/divide unit for the datapath. Takes two 32-bit operands captured from the bus, iterates one bit per clock, and produces a 64-bit result split into HI and LO words. The HI and LO words drive the inputs of the HI and LO `register32` instances. A one-cycle write strobe is the enable for both registers.

## Interface
- `DATA_WIDTH`, default 32: operand width and width of each result word. Must be even and ≥ 4.
- `clock` input 1: sole clock, rising edge.
- `clear` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only when the FSM is in IDLE or DONE.
- `op` input 1: 0 = multiply, 1 = divide. Sampled with `start`.
- `a` input DATA_WIDTH: multiplicand or dividend, signed two's complement. Sampled with `start`.
- `b` input DATA_WIDTH: multiplier or divisor, signed. Sampled with `start`.
- `busy` output 1: high while the operation is in progress (PREP, ITER, FIX).
- `done` output 1: one-cycle pulse, high in DONE. Serves as the write enable for the HI/LO registers.
- `div_by_zero` output 1: valid with `done`. Held until the next accepted `start`.
- `hi` output DATA_WIDTH: upper product word, or remainder for divide.
- `lo` output DATA_WIDTH: lower product word, or quotient for divide.

## Operation
- States:
  - IDLE → PREP on `start`.
  - PREP → ITER.
  - ITER stays in ITER for DATA_WIDTH cycles (iteration counter runs 0..DATA_WIDTH-1), then → FIX.
  - FIX → DONE.
  - DONE → PREP if `start` is high, else → IDLE.
- Accept: the edge with `start`=1 in IDLE or DONE captures `op`, `a` and `b`, and clears `div_by_zero`.
  - `start` during PREP, ITER or FIX is ignored. Captured operands are unaffected.
- PREP: form the absolute values of both operands. Record the result signs:
  - multiply: sign(a) XOR sign(b);
  - divide: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- ITER, multiply: unsigned shift-add on the magnitudes, one multiplier bit per cycle, with a 2·DATA_WIDTH accumulator.
- ITER, divide: unsigned restoring division, one quotient bit per cycle, with a DATA_WIDTH+1-bit partial remainder.
- FIX: apply two's-complement negation where the recorded sign is 1. Load `hi`/`lo`.
- Divide results:
  - the quotient truncates toward zero;
  - the remainder takes the sign of the dividend;
  - a = q·b + r holds exactly.
- Most-negative operand: the magnitude of -2^(DATA_WIDTH-1) is held in DATA_WIDTH+1 bits, so no overflow occurs in PREP.
  - Multiply results are exact over the full 64-bit range.
  - Divide: -2^(DATA_WIDTH-1) / -1 yields `lo` = 0x8000_0000 and `hi` = 0 (wraps, no flag).
- Divide by zero: detected in PREP. The FSM still runs ITER and FIX (fixed latency). In FIX:
  - `hi` ← a;
  - `lo` ← all ones;
  - `div_by_zero` ← 1.
- `hi`/`lo` change only in FIX. They hold their value from DONE onward until the next FIX.
- Reset (`clear`=0, any state, including mid-ITER): all of the following go to 0 immediately, and the state goes to IDLE:
  - `hi`, `lo`, `busy`, `done`, `div_by_zero`;
  - the internal accumulator and counter.
  - An in-flight operation is discarded and produces no `done`.

## Timing
- Reset values: every output is 0.
- Accept edge = cycle 0. Then:
  - PREP in cycle 1;
  - ITER in cycles 2..DATA_WIDTH+1;
  - FIX in cycle DATA_WIDTH+2;
  - DONE in cycle DATA_WIDTH+3.
- Latency: DATA_WIDTH+3 cycles from the accept edge to `done` (35 for the default).
- `busy` is high in cycles 1..DATA_WIDTH+2. `busy` and `done` are never high together.
- `hi`/`lo` are already stable in the cycle `done` is high. A HI/LO register enabled by `done` captures them on the following edge.
- Back-to-back: `start` held high in DONE starts the next operation with no IDLE cycle. Throughput is one result per DATA_WIDTH+3 cycles.
- Outputs are registered; there is no combinational path from the inputs to the outputs.

## Test plan
- Multiply 7 × -3: `done` goes high exactly 35 cycles after the accept edge, with `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB, `busy` low that cycle, and `done` low one cycle later.
- Multiply 0x8000_0000 × 0x8000_0000: `hi`=0x4000_0000, `lo`=0x0000_0000.
- Divide signs:
  - -7 / 2 → `lo`=0xFFFF_FFFD (-3), `hi`=0xFFFF_FFFF (-1).
  - 7 / -2 → `lo`=0xFFFF_FFFD, `hi`=0x0000_0001.
- Divide 100 / 0: `done` at cycle 35 with `div_by_zero`=1, `hi`=100, `lo`=0xFFFF_FFFF. A following 100 / 7 clears the flag at accept and yields `lo`=14, `hi`=2.
- Pulse `start` at cycles 5 and 20 of an operation with different operands: both pulses are ignored, and the original result appears at cycle 35.
- Reset during ITER:
  - Drive `clear` low at cycle 10. All outputs read 0 immediately and no `done` follows.
  - After release, a new 3 × 4 gives `lo`=12 and `hi`=0 at cycle 35.
- Hold `start` high through DONE: the second operation's `done` arrives exactly 35 cycles after the first `done`.
